// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage pipeline datapath and the
// central stall/flush sequencer.
//   master : pipeline side. It drives the hazard sources (ID operands,
//            EX load info, MEM branch result, data-memory handshake) and
//            receives the stage enables, flushes and performance counters.
//   slave  : sequencer side (pipeline_hazard_ctrl).
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  // hazard sources
  logic [4:0]       ifid_rs1;
  logic [4:0]       ifid_rs2;
  logic             idex_memread;
  logic [4:0]       idex_rd;
  logic             exmem_branch;
  logic             exmem_zero;
  logic             dmem_req;
  logic             dmem_ready;
  // pipeline controls
  logic             pc_write;
  logic             pc_redirect;
  logic             ifid_write;
  logic             idex_write;
  logic             exmem_write;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             memwb_flush;
  // status and performance counters
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output ifid_rs1, ifid_rs2, idex_memread, idex_rd,
           exmem_branch, exmem_zero, dmem_req, dmem_ready,
    input  pc_write, pc_redirect, ifid_write, idex_write, exmem_write,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           mem_timeout, stall_cycles, flush_events
  );

  modport slave (
    input  ifid_rs1, ifid_rs2, idex_memread, idex_rd,
           exmem_branch, exmem_zero, dmem_req, dmem_ready,
    output pc_write, pc_redirect, ifid_write, idex_write, exmem_write,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           mem_timeout, stall_cycles, flush_events
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage core.
// Combines three hazard sources into same-cycle (Mealy) stage controls:
//   - multi-cycle data-memory access (dmem_req & ~dmem_ready): freeze PC..EX/MEM,
//     bubble into MEM/WB;
//   - taken branch resolved in MEM: redirect PC, flush IF/ID, ID/EX, EX/MEM;
//   - load-use hazard in ID: hold PC and IF/ID, bubble into ID/EX.
// Priority: memory stall > taken branch > load-use.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high
//   hz    : slave side of pipeline_hazard_ctrl_if (hazard inputs, stage
//           controls, sticky mem_timeout, stall_cycles / flush_events counters)
module pipeline_hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              timeout_q;
  logic [CNT_W-1:0]  stall_q, flush_q;

  logic mem_stall, br_taken, load_use;
  logic pc_write, pc_redirect, ifid_write, idex_write, exmem_write;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush;

  assign mem_stall = hz.dmem_req & ~hz.dmem_ready;
  assign br_taken  = hz.exmem_branch & hz.exmem_zero;
  assign load_use  = hz.idex_memread && (hz.idex_rd != 5'd0) &&
                     ((hz.idex_rd == hz.ifid_rs1) || (hz.idex_rd == hz.ifid_rs2));

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    pc_write    = 1'b1;
    pc_redirect = 1'b0;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;

    // While reset is held the idle RUN controls are presented.
    if (!reset) begin
      unique case (state)
        RUN: begin
          if (mem_stall) begin
            state_nxt = MEM_WAIT;
            wait_nxt  = WAIT_W'(1);
          end else begin
            wait_nxt  = '0;
          end
        end
        MEM_WAIT: begin
          // A dropped dmem_req is a protocol violation and is treated as ready.
          if (mem_stall) begin
            if (wait_cnt != WAIT_MAX) wait_nxt = wait_cnt + WAIT_W'(1);
          end else begin
            state_nxt = RUN;
            wait_nxt  = '0;
          end
        end
        default: begin
          state_nxt = RUN;
          wait_nxt  = '0;
        end
      endcase

      // The freeze is identical on the entry cycle and every waiting cycle; on
      // the ready cycle a deferred branch or load-use takes effect at once.
      if (mem_stall) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_write  = 1'b0;
        exmem_write = 1'b0;
        memwb_flush = 1'b1;
      end else if (br_taken) begin
        // Squashes any load-use seen in the same cycle.
        pc_redirect = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (load_use) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_flush  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      // Sticky: the FSM never aborts the access, it only reports it.
      if (mem_stall && (wait_nxt == WAIT_MAX)) timeout_q <= 1'b1;
      if (!pc_write && (stall_q != '1))  stall_q <= stall_q + CNT_W'(1);
      if (pc_redirect && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign hz.pc_write     = pc_write;
  assign hz.pc_redirect  = pc_redirect;
  assign hz.ifid_write   = ifid_write;
  assign hz.idex_write   = idex_write;
  assign hz.exmem_write  = exmem_write;
  assign hz.ifid_flush   = ifid_flush;
  assign hz.idex_flush   = idex_flush;
  assign hz.exmem_flush  = exmem_flush;
  assign hz.memwb_flush  = memwb_flush;
  assign hz.mem_timeout  = timeout_q;
  assign hz.stall_cycles = stall_q;
  assign hz.flush_events = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl (CNT_W=4, MEM_TIMEOUT=4 so counter
// saturation and the timeout are reachable in a short run).
// The stimulus process drives one cycle at a time and pushes the expected
// response, computed from a behavioural model, into a queue; the monitor pops
// one entry on every falling edge and compares it with the DUT outputs.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 4;
  localparam int SAT         = (1 << CNT_W) - 1;

  // Control bundle order:
  // {pc_write, pc_redirect, ifid_write, idex_write, exmem_write,
  //  ifid_flush, idex_flush, exmem_flush, memwb_flush}
  localparam logic [8:0] C_IDLE   = 9'b1_0_111_0000;
  localparam logic [8:0] C_FREEZE = 9'b0_0_000_0001;
  localparam logic [8:0] C_BRANCH = 9'b1_1_111_1110;
  localparam logic [8:0] C_LDUSE  = 9'b0_0_011_0100;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       memread;
    logic [4:0] rd;
    logic       branch;
    logic       zero;
    logic       req;
    logic       ready;
  } hz_t;

  typedef struct packed {
    logic [8:0] ctrl;
    logic       timeout;
    int         stall;
    int         flush;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz_if ();

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz_if.slave)
  );

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  // Behavioural model state: counters, length of the current run of
  // consecutive memory-stall cycles, and the sticky timeout.
  int m_stall = 0;
  int m_flush = 0;
  int m_run   = 0;
  bit m_to    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock cycle of stimulus plus its expected response.
  task automatic step(input logic rst, input hz_t h);
    exp_t e;
    bit   stall_now, br, lu;
    reset                = rst;
    hz_if.ifid_rs1       = h.rs1;
    hz_if.ifid_rs2       = h.rs2;
    hz_if.idex_memread   = h.memread;
    hz_if.idex_rd        = h.rd;
    hz_if.exmem_branch   = h.branch;
    hz_if.exmem_zero     = h.zero;
    hz_if.dmem_req       = h.req;
    hz_if.dmem_ready     = h.ready;

    e.timeout = m_to;
    e.stall   = m_stall;
    e.flush   = m_flush;
    if (rst) begin
      e.ctrl  = C_IDLE;
      m_stall = 0;
      m_flush = 0;
      m_run   = 0;
      m_to    = 1'b0;
    end else begin
      stall_now = h.req && !h.ready;
      br        = h.branch && h.zero;
      lu        = h.memread && (h.rd != 0) && (h.rd == h.rs1 || h.rd == h.rs2);
      if (stall_now)  e.ctrl = C_FREEZE;
      else if (br)    e.ctrl = C_BRANCH;
      else if (lu)    e.ctrl = C_LDUSE;
      else            e.ctrl = C_IDLE;
      if (!e.ctrl[8]) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
      if (e.ctrl[7])  m_flush = (m_flush < SAT) ? m_flush + 1 : SAT;
      m_run = stall_now ? m_run + 1 : 0;
      if (m_run >= MEM_TIMEOUT) m_to = 1'b1;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: the DUT presents a full control set every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ctrl", 32'({hz_if.pc_write, hz_if.pc_redirect, hz_if.ifid_write,
                         hz_if.idex_write, hz_if.exmem_write, hz_if.ifid_flush,
                         hz_if.idex_flush, hz_if.exmem_flush, hz_if.memwb_flush}),
            32'(e.ctrl));
      check("mem_timeout",  32'(hz_if.mem_timeout),  32'(e.timeout));
      check("stall_cycles", 32'(hz_if.stall_cycles), e.stall);
      check("flush_events", 32'(hz_if.flush_events), e.flush);
    end
  end

  initial begin
    hz_t idle, h;
    idle = '{rs1: 5'd1, rs2: 5'd2, memread: 1'b0, rd: 5'd0,
             branch: 1'b0, zero: 1'b0, req: 1'b0, ready: 1'b0};

    // Drive idle inputs and let the first edge clear the registers.
    hz_if.ifid_rs1 = idle.rs1;     hz_if.ifid_rs2 = idle.rs2;
    hz_if.idex_memread = 1'b0;     hz_if.idex_rd = 5'd0;
    hz_if.exmem_branch = 1'b0;     hz_if.exmem_zero = 1'b0;
    hz_if.dmem_req = 1'b0;         hz_if.dmem_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset state, then idle running.
    step(1'b1, idle);
    step(1'b0, idle);

    // Load-use: ld x5 in EX, ID reads x5.
    h = idle; h.memread = 1'b1; h.rd = 5'd5; h.rs1 = 5'd5;
    step(1'b0, h);
    step(1'b0, idle);
    // Same via rs2.
    h = idle; h.memread = 1'b1; h.rd = 5'd7; h.rs2 = 5'd7;
    step(1'b0, h);

    // x0 destination never stalls.
    h = idle; h.memread = 1'b1; h.rd = 5'd0; h.rs1 = 5'd0;
    step(1'b0, h);

    // Taken branch squashes a simultaneous load-use; untaken branch is idle.
    step(1'b1, idle);
    h = idle; h.memread = 1'b1; h.rd = 5'd3; h.rs1 = 5'd3;
    h.branch = 1'b1; h.zero = 1'b1;
    step(1'b0, h);
    h.zero = 1'b0;
    step(1'b0, h);
    step(1'b0, idle);

    // Memory stall for 3 cycles with a taken branch held in MEM, then ready.
    step(1'b1, idle);
    h = idle; h.branch = 1'b1; h.zero = 1'b1; h.req = 1'b1; h.ready = 1'b0;
    repeat (3) step(1'b0, h);
    h.ready = 1'b1;
    step(1'b0, h);
    step(1'b0, idle);

    // Timeout: ready low for 6 cycles, flag stays after ready.
    step(1'b1, idle);
    h = idle; h.req = 1'b1; h.ready = 1'b0;
    repeat (6) step(1'b0, h);
    h.ready = 1'b1;
    step(1'b0, h);
    repeat (2) step(1'b0, idle);

    // Dropped request during the wait acts as ready.
    h = idle; h.req = 1'b1; h.ready = 1'b0;
    step(1'b0, h);
    step(1'b0, idle);

    // Stall counter saturation, then reset in the middle of a wait.
    repeat (20) step(1'b0, h);
    step(1'b1, h);
    step(1'b0, idle);
    step(1'b0, idle);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      h.rs1     = 5'($urandom_range(0, 3));
      h.rs2     = 5'($urandom_range(0, 3));
      h.rd      = 5'($urandom_range(0, 3));
      h.memread = ($urandom_range(0, 1) == 1);
      h.branch  = ($urandom_range(0, 9) < 3);
      h.zero    = ($urandom_range(0, 1) == 1);
      h.req     = ($urandom_range(0, 9) < 5);
      h.ready   = ($urandom_range(0, 9) < 4);
      step(($urandom_range(0, 59) == 0), h);
    end
    step(1'b0, idle);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
